dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the memory-side end of the datapath's load/store interface.
//  Accepts one request at a time from the datapath (initiator) over a valid/ready handshake.
//  Performs a byte-enabled write or a word read on an internal word-addressed array.
//  Returns a response (read data and error flag) over a second valid/ready channel after DELAY wait cycles.
// PARAMETERS
//  BIT_WIDTH   32  data word width; multiple of 8; BE width = BIT_WIDTH/8
//  ADDR_WIDTH  32  byte address width of req_addr
//  DEPTH_LOG2  10  log2 of array depth in words (1024 words default)
//  DELAY       0   extra wait cycles between accept and response (0..15)
// PORTS
//  clk         in   1             single clock, all logic on rising edge
//  rst         in   1             synchronous, active-high reset
//  req_valid   in   1             request present
//  req_ready   out  1             responder can accept request
//  req_we      in   1             1=store, 0=load
//  req_addr    in   ADDR_WIDTH    byte address
//  req_wdata   in   BIT_WIDTH     store data
//  req_be      in   BIT_WIDTH/8   store byte enables (ignored on load)
//  resp_valid  out  1             response present
//  resp_ready  in   1             initiator accepts response
//  resp_rdata  out  BIT_WIDTH     load data (0 for stores and errors)
//  resp_err    out  1             address out of range or misaligned
// BEHAVIOUR
//  Reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE, wait counter=0; array contents NOT cleared.
//  FSM: IDLE -> (DELAY>0 ? WAIT : RESP) on accept; WAIT counts DELAY cycles -> RESP; RESP -> IDLE when resp_valid&&resp_ready.
//  Accept = req_valid && req_ready; req_ready=1 only in IDLE. All request fields are registered on accept.
//  Word index = addr[DEPTH_LOG2+log2(BIT_WIDTH/8)-1 : log2(BIT_WIDTH/8)].
//  Out of range: any addr bit above the index field is set -> resp_err=1, no write, rdata=0.
//  Store: bytes with be[i]=1 are written at the accept edge; other bytes unchanged; be=0 is a legal no-op.
//  Load: data is read at the accept edge; resp_rdata is held stable throughout RESP.
//  Latency: resp_valid asserts exactly DELAY+1 cycles after the accept edge.
//  Response holds (valid, rdata, err stable) until resp_ready; no new accept until the cycle after the handshake.
//  Back-to-back: with resp_ready tied to 1 and DELAY=0, throughput is one request per 2 cycles.
//  Load after store to same word returns the stored data (store commits before the next accept).
//  rst mid-operation: in-flight request is discarded; a store already committed at accept remains.
//  req_valid in a non-IDLE state is ignored (not queued); the initiator holds it until req_ready.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined: a load with addr low bits != 0, or a store whose addr low bits != 0,
//    gives resp_err=1, no write, rdata=0.
//  Undefined: low addr bits are ignored (access forced word-aligned); the misaligned condition never sets resp_err.
// TESTING
//  DELAY=0: store 0xDEADBEEF at 0x10 with be=4'hF, then load 0x10 -> rdata=0xDEADBEEF, err=0, resp_valid 1 cycle after accept.
//  Partial store: store 0x000000AA at 0x10 with be=4'b0001 -> load 0x10 returns 0xDEADBEAA.
//  DELAY=3, resp_ready held 0 for 5 cycles -> resp_valid at accept+4, rdata stable, req_ready=0 until the cycle after the handshake.
//  Out of range: load 0x0000_1000 (DEPTH_LOG2=10) -> err=1, rdata=0; store there does not alias word 0.
//  Misaligned load at 0x12: with DMEM_ALIGN_CHECK_EN -> err=1; without -> returns word at 0x10, err=0.
//  rst asserted in WAIT -> next cycle req_ready=1, resp_valid=0; the preceding store's data persists on reload.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store with DELAY-cycle response latency.
// Define DMEM_ALIGN_CHECK_EN to flag accesses with nonzero low address bits as errors.
module dmem_responder #(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DELAY      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [BIT_WIDTH-1:0]   req_wdata,
  input  logic [BIT_WIDTH/8-1:0] req_be,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [BIT_WIDTH-1:0]   resp_rdata,
  output logic                   resp_err
);

  localparam int unsigned BE_W    = BIT_WIDTH / 8;
  localparam int unsigned OFF_W   = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int unsigned IDX_TOP = DEPTH_LOG2 + OFF_W;
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [BIT_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                   resp_err_q, resp_err_d;

  logic [BIT_WIDTH-1:0]   mem_q [DEPTH];

  logic                   accept_c;
  logic                   out_of_range_c;
  logic                   err_c;
  logic [DEPTH_LOG2-1:0]  idx_c;

  assign accept_c       = req_valid && req_ready_q;
  assign out_of_range_c = (req_addr >> IDX_TOP) != '0;
  assign idx_c          = DEPTH_LOG2'(req_addr >> OFF_W);

`ifdef DMEM_ALIGN_CHECK_EN
  assign err_c = out_of_range_c || ((req_addr & ADDR_WIDTH'(BE_W - 1)) != '0);
`else
  assign err_c = out_of_range_c;
`endif

  // Next-state and registered-output computation; results captured at the accept edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          resp_err_d   = err_c;
          resp_rdata_d = (err_c || req_we) ? '0 : mem_q[idx_c];
          cnt_d        = '0;
          state_d      = (DELAY > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(DELAY - 1)) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Store commits at the accept edge so a following load sees it; array is never reset.
  always_ff @(posedge clk) begin
    if (!rst && accept_c && req_we && !err_c) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (req_be[b]) begin
          mem_q[idx_c][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (DELAY=0 and DELAY=3) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_dmem_responder;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        rst        [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic [3:0]  req_be     [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.BIT_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .DELAY(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0])
  );

  dmem_responder #(.BIT_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .DELAY(3)) u_dut3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1])
  );

  function automatic int dly(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: busy flag + edge count since accept, and a sparse word memory.
  bit          m_busy  [NI];
  int          m_age   [NI];
  logic [31:0] m_rd    [NI];
  logic        m_err   [NI];
  bit          m_known [NI];
  logic [31:0] m_mem   [int unsigned];

  task automatic model_accept(input int i);
    logic [31:0] a;
    logic [31:0] w;
    bit          e;
    int unsigned key;
    a = req_addr[i];
    e = (a >> 12) != 0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) e = 1'b1;
`endif
    key = int'(i) * 4096 + int'(a[11:2]);
    m_busy[i]  = 1'b1;
    m_age[i]   = 0;
    m_err[i]   = e;
    m_known[i] = 1'b1;
    m_rd[i]    = 32'h0;
    if (!e && req_we[i]) begin
      if (m_mem.exists(key) || req_be[i] == 4'hF) begin
        w = m_mem.exists(key) ? m_mem[key] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (req_be[i][b]) w[b*8 +: 8] = req_wdata[i][b*8 +: 8];
        m_mem[key] = w;
      end
    end else if (!e) begin
      if (m_mem.exists(key)) m_rd[i] = m_mem[key];
      else m_known[i] = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        m_busy[i] = 1'b0; m_age[i] = 0; m_rd[i] = 32'h0; m_err[i] = 1'b0; m_known[i] = 1'b1;
      end else if (m_busy[i]) begin
        if (m_age[i] >= dly(i) && resp_ready[i]) m_busy[i] = 1'b0;
        else m_age[i]++;
      end else if (req_valid[i]) begin
        model_accept(i);
      end
    end
  end

  // Every-cycle compare of DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int i = 0; i < NI; i++) begin
        bit ev;
        ev = m_busy[i] && (m_age[i] >= dly(i));
        check($sformatf("m_ready%0d", i), 32'(req_ready[i]), 32'(!m_busy[i]));
        check($sformatf("m_valid%0d", i), 32'(resp_valid[i]), 32'(ev));
        if (ev) begin
          check($sformatf("m_err%0d", i), 32'(resp_err[i]), 32'(m_err[i]));
          if (m_known[i]) check($sformatf("m_rdata%0d", i), resp_rdata[i], m_rd[i]);
        end
      end
    end
  end

  task automatic xact(input int i, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd = 32'h0; er = 1'b0; lat = 0; n = 0;
    @(negedge clk);
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = addr;
    req_wdata[i] = wdata; req_be[i] = be; resp_ready[i] = 1'b0;
    while (!req_ready[i] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[i]) begin
      check("accept_timeout", 32'(req_ready[i]), 32'd1);
      req_valid[i] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = 1;
    while (!resp_valid[i] && lat < 50) begin @(negedge clk); lat++; end
    if (!resp_valid[i]) begin
      check("resp_timeout", 32'(resp_valid[i]), 32'd1);
      return;
    end
    rd = resp_rdata[i]; er = resp_err[i];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid[i]), 32'd1);
      check("hold_req_ready", 32'(req_ready[i]), 32'd0);
    end
    resp_ready[i] = 1'b1;
    @(negedge clk);
    resp_ready[i] = 1'b0;
    check("post_hs_ready", 32'(req_ready[i]), 32'd1);
    check("post_hs_valid", 32'(resp_valid[i]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          vcnt;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0; req_be[i] = 4'h0; resp_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    for (int i = 0; i < NI; i++) begin
      check("rst_ready", 32'(req_ready[i]), 32'd1);
      check("rst_valid", 32'(resp_valid[i]), 32'd0);
      check("rst_rdata", resp_rdata[i], 32'h0);
      check("rst_err", 32'(resp_err[i]), 32'd0);
      rst[i] = 1'b0;
    end

    // DELAY=0 instance
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("st_lat0", 32'(lat), 32'd1);
    check("st_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld_data", rd, 32'hDEADBEEF);
    check("ld_lat0", 32'(lat), 32'd1);
    xact(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, rd, er, lat);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("partial_st", rd, 32'hDEADBEAA);
    xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("be0_noop", rd, 32'hDEADBEAA);
    xact(0, 1'b1, 32'h0, 32'h01234567, 4'hF, 0, rd, er, lat);
    xact(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    check("oor_st_err", 32'(er), 32'd1);
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    check("no_alias", rd, 32'h01234567);
    xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, rd, er, lat);
    check("oor_ld_err", 32'(er), 32'd1);
    check("oor_ld_rdata", rd, 32'h0);
    xact(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_ld_err", 32'(er), 32'd1);
    check("mis_ld_rdata", rd, 32'h0);
`else
    check("mis_ld_err", 32'(er), 32'd0);
    check("mis_ld_rdata", rd, 32'hDEADBEAA);
`endif
    xact(0, 1'b1, 32'h11, 32'h55555555, 4'hF, 0, rd, er, lat);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_st_nowrite", rd, 32'hDEADBEAA);
`else
    check("mis_st_write", rd, 32'h55555555);
`endif

    // Back-to-back with resp_ready tied high: one response every 2 cycles
    @(negedge clk);
    resp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid[0]) vcnt++;
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    resp_ready[0] = 1'b0;
    check("b2b_count", 32'(vcnt), 32'd4);

    // DELAY=3 instance
    xact(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
    check("st_lat3", 32'(lat), 32'd4);
    xact(1, 1'b0, 32'h20, 32'h0, 4'h0, 5, rd, er, lat);
    check("ld_lat3", 32'(lat), 32'd4);
    check("ld3_data", rd, 32'h11223344);

    // Reset while waiting: in-flight response dropped, committed store kept
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h40;
    req_wdata[1] = 32'hA5A50F0F; req_be[1] = 4'hF;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check("rst_wait_ready", 32'(req_ready[1]), 32'd1);
    check("rst_wait_valid", 32'(resp_valid[1]), 32'd0);
    xact(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat);
    check("rst_persist", rd, 32'hA5A50F0F);
    xact(1, 1'b0, 32'h2000, 32'h0, 4'h0, 0, rd, er, lat);
    check("oor3_err", 32'(er), 32'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
